// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU control decoder and the iterative MDU.
// Holds alu_op codes, ALU control codes, funct constants and the FSM state type.
package alu_ctrl_pkg;

    localparam logic [1:0] ALU_OP_ADD   = 2'd0;
    localparam logic [1:0] ALU_OP_SUB   = 2'd1;
    localparam logic [1:0] ALU_OP_RTYPE = 2'd2;

    localparam logic [3:0] ALU_CTL_AND  = 4'd0;
    localparam logic [3:0] ALU_CTL_OR   = 4'd1;
    localparam logic [3:0] ALU_CTL_ADD  = 4'd2;
    localparam logic [3:0] ALU_CTL_SLL  = 4'd3;
    localparam logic [3:0] ALU_CTL_SRL  = 4'd4;
    localparam logic [3:0] ALU_CTL_SUB  = 4'd5;
    localparam logic [3:0] ALU_CTL_SLT  = 4'd7;
    localparam logic [3:0] ALU_CTL_MFHI = 4'd8;
    localparam logic [3:0] ALU_CTL_MFLO = 4'd9;
    localparam logic [3:0] ALU_CTL_NOR  = 4'd12;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_mdu_funct(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/alu_mdu_control_if.sv
// EX-stage bundle between the pipeline (master) and the ALU control / MDU block (slave).
interface alu_mdu_control_if #(
    parameter int unsigned DATA_W = 32
);
    logic              valid_in;
    logic              flush;
    logic [1:0]        alu_op;
    logic [5:0]        function_field;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [3:0]        alu_control;
    logic              stall;
    logic              mdu_done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output valid_in, flush, alu_op, function_field, op_a, op_b,
        input  alu_control, stall, mdu_done, hi, lo
    );

    modport slave (
        input  valid_in, flush, alu_op, function_field, op_a, op_b,
        output alu_control, stall, mdu_done, hi, lo
    );
endinterface

// File: rtl/alu_mdu_control_mdu_iter.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring divide
// over unsigned magnitudes, one bit per step. res_hi/res_lo show the result of the pending step.
module mdu_iter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [DATA_W-1:0] a_mag,
    input  logic [DATA_W-1:0] b_mag,
    output logic [DATA_W-1:0] res_hi,
    output logic [DATA_W-1:0] res_lo,
    output logic [CNT_W-1:0]  cnt
);
    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] acc_d;
    logic [DATA_W-1:0]   opnd_q;
    logic                div_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W-1:0]   div_diff;
    logic                div_ge;

    // Divide keeps {remainder, dividend/quotient} in acc; multiply keeps {partial, multiplier}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[2*DATA_W-1:DATA_W-1];
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift[DATA_W-1:0] - opnd_q;
        if (div_q) begin
            acc_d = {(div_ge ? div_diff : div_shift[DATA_W-1:0]), acc_q[DATA_W-2:0], div_ge};
        end else begin
            acc_d = {mul_sum, acc_q[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (load) begin
            acc_q  <= {{DATA_W{1'b0}}, (is_div ? a_mag : b_mag)};
            opnd_q <= is_div ? b_mag : a_mag;
            div_q  <= is_div;
            cnt_q  <= '0;
        end else if (step) begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    assign res_hi = acc_d[2*DATA_W-1:DATA_W];
    assign res_lo = acc_d[DATA_W-1:0];
    assign cnt    = cnt_q;

endmodule

// File: rtl/alu_mdu_control.sv
// EX-stage ALU control decoder plus iterative MULT/DIV unit with HI/LO,
// pipeline stall request and flush abort.
module alu_mdu_control
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic             clk,
    input  logic             arst,
    alu_mdu_control_if.slave bus
);
    mdu_state_e        state_q, state_d;
    logic [3:0]        alu_ctl;
    logic              mdu_start, last_step;
    logic              load, step, res_we, stall, mdu_done;

    logic              op_signed, op_div, a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;

    logic              op_div_q, neg_lo_q, neg_hi_q, div_zero_q;
    logic [DATA_W-1:0] a_raw_q, hi_q, lo_q;

    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   res_hi, res_lo;
    logic [2*DATA_W-1:0] prod;

    always_comb begin
        alu_ctl = ALU_CTL_AND;
        case (bus.alu_op)
            ALU_OP_ADD: alu_ctl = ALU_CTL_ADD;
            ALU_OP_SUB: alu_ctl = ALU_CTL_SUB;
            ALU_OP_RTYPE: begin
                case (bus.function_field)
                    FUNCT_ADD:  alu_ctl = ALU_CTL_ADD;
                    FUNCT_SUB:  alu_ctl = ALU_CTL_SUB;
                    FUNCT_AND:  alu_ctl = ALU_CTL_AND;
                    FUNCT_OR:   alu_ctl = ALU_CTL_OR;
                    FUNCT_NOR:  alu_ctl = ALU_CTL_NOR;
                    FUNCT_SLT:  alu_ctl = ALU_CTL_SLT;
                    FUNCT_SLL:  alu_ctl = ALU_CTL_SLL;
                    FUNCT_SRL:  alu_ctl = ALU_CTL_SRL;
                    FUNCT_MFHI: alu_ctl = ALU_CTL_MFHI;
                    FUNCT_MFLO: alu_ctl = ALU_CTL_MFLO;
                    default:    alu_ctl = ALU_CTL_AND;
                endcase
            end
            default: alu_ctl = ALU_CTL_AND;
        endcase
    end

    // funct[0] clear selects the signed variant, funct[1] set selects divide.
    assign op_signed = ~bus.function_field[0];
    assign op_div    = bus.function_field[1];
    assign a_neg     = op_signed & bus.op_a[DATA_W-1];
    assign b_neg     = op_signed & bus.op_b[DATA_W-1];
    assign a_mag     = a_neg ? -bus.op_a : bus.op_a;
    assign b_mag     = b_neg ? -bus.op_b : bus.op_b;

    assign mdu_start = bus.valid_in & ~bus.flush & (bus.alu_op == ALU_OP_RTYPE) &
                       is_mdu_funct(bus.function_field) & (state_q == ST_IDLE);
    assign last_step = (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mdu_start) state_d = ST_BUSY;
            ST_BUSY: begin
                if (bus.flush)      state_d = ST_IDLE;
                else if (last_step) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // DONE never requests a start, so the still-held MDU instruction cannot re-issue.
    always_comb begin
        load     = 1'b0;
        step     = 1'b0;
        res_we   = 1'b0;
        stall    = 1'b0;
        mdu_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load  = mdu_start;
                stall = mdu_start;
            end
            ST_BUSY: begin
                stall  = ~bus.flush;
                step   = ~bus.flush;
                res_we = ~bus.flush & last_step;
            end
            ST_DONE: mdu_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            op_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            div_zero_q <= 1'b0;
            a_raw_q    <= '0;
        end else if (load) begin
            op_div_q   <= op_div;
            neg_lo_q   <= a_neg ^ b_neg;
            neg_hi_q   <= a_neg;
            div_zero_q <= op_div & (bus.op_b == '0);
            a_raw_q    <= bus.op_a;
        end
    end

    mdu_iter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_mdu_iter (
        .clk    (clk),
        .arst   (arst),
        .load   (load),
        .step   (step),
        .is_div (op_div),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .cnt    (cnt)
    );

    assign prod = {res_hi, res_lo};

    // Sign correction on the final step; divide-by-zero returns all-ones / dividend.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (res_we) begin
            if (!op_div_q) begin
                {hi_q, lo_q} <= neg_lo_q ? -prod : prod;
            end else if (div_zero_q) begin
                hi_q <= a_raw_q;
                lo_q <= '1;
            end else begin
                lo_q <= neg_lo_q ? -res_lo : res_lo;
                hi_q <= neg_hi_q ? -res_hi : res_hi;
            end
        end
    end

    assign bus.alu_control = alu_ctl;
    assign bus.stall       = stall;
    assign bus.mdu_done    = mdu_done;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_alu_mdu_control.sv
// Directed bench for alu_mdu_control: decode sweep, MDU ops with a result
// scoreboard checked by an independent done monitor, flush abort and async reset.
module tb_alu_mdu_control;
    import alu_ctrl_pkg::*;

    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    alu_mdu_control_if #(.DATA_W(DATA_W)) bus ();

    alu_mdu_control #(.DATA_W(DATA_W)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus.slave)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Result monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (arst === 1'b0 && bus.mdu_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_mdu_done", 64'(bus.mdu_done), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("mdu_result_hi_lo", {bus.hi, bus.lo}, e);
                end
            end
        end
    end

    task automatic decode_vec(input logic [1:0] op, input logic [5:0] f,
                              input logic [3:0] exp, input string name);
        @(negedge clk);
        bus.valid_in       = 1'b1;
        bus.alu_op         = op;
        bus.function_field = f;
        #1;
        check(name, 64'(bus.alu_control), 64'(exp));
        check({name, "_stall"}, 64'(bus.stall), 64'd0);
    endtask

    task automatic issue_mdu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.valid_in       = 1'b1;
        bus.flush          = 1'b0;
        bus.alu_op         = ALU_OP_RTYPE;
        bus.function_field = f;
        bus.op_a           = a;
        bus.op_b           = b;
    endtask

    // Instruction is held valid while stalled and through DONE, then retired.
    task automatic run_mdu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input string name);
        int stall_cycles;
        exp_q.push_back({exp_hi, exp_lo});
        issue_mdu(f, a, b);
        #1;
        stall_cycles = 0;
        for (int i = 0; i < 40 && bus.stall === 1'b1; i++) begin
            stall_cycles++;
            @(negedge clk);
            #1;
        end
        check({name, "_stall_len"}, 64'(stall_cycles), 64'd33);
        check({name, "_done_pulse"}, 64'(bus.mdu_done), 64'd1);
        @(negedge clk);
        bus.valid_in = 1'b0;
        #1;
        check({name, "_no_restart"}, 64'(bus.stall), 64'd0);
        check({name, "_done_cleared"}, 64'(bus.mdu_done), 64'd0);
    endtask

    initial begin
        arst               = 1'b1;
        bus.valid_in       = 1'b0;
        bus.flush          = 1'b0;
        bus.alu_op         = ALU_OP_ADD;
        bus.function_field = 6'd0;
        bus.op_a           = '0;
        bus.op_b           = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_stall", 64'(bus.stall), 64'd0);
        check("reset_done", 64'(bus.mdu_done), 64'd0);
        check("reset_hi_lo", {bus.hi, bus.lo}, 64'd0);
        arst = 1'b0;

        decode_vec(2'd0, 6'b000000, 4'd2,  "dec_add");
        decode_vec(2'd1, 6'b000000, 4'd5,  "dec_sub");
        decode_vec(2'd2, 6'b100111, 4'd12, "dec_nor");
        decode_vec(2'd2, 6'b000010, 4'd4,  "dec_srl");
        decode_vec(2'd2, 6'b010010, 4'd9,  "dec_mflo");
        decode_vec(2'd2, 6'b010000, 4'd8,  "dec_mfhi");
        decode_vec(2'd2, 6'b101010, 4'd7,  "dec_slt");
        decode_vec(2'd2, 6'b100101, 4'd1,  "dec_or");
        decode_vec(2'd2, 6'b111111, 4'd0,  "dec_unknown");
        decode_vec(2'd3, 6'b100000, 4'd0,  "dec_op3");
        @(negedge clk);
        bus.valid_in = 1'b0;

        run_mdu(6'b011000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_7_m3");
        run_mdu(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("multu_idle_after", 64'(bus.stall), 64'd0);
        end
        run_mdu(6'b011010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        run_mdu(6'b011011, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, "divu_by_zero");
        run_mdu(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_m1");
        run_mdu(6'b011000, 32'd3, 32'd5, 32'd0, 32'd15, "mult_preload");

        // Flush in the 10th BUSY cycle of DIVU 9/4.
        issue_mdu(6'b011011, 32'd9, 32'd4);
        for (int i = 0; i < 10; i++) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("flush_stall_same_cycle", 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.valid_in = 1'b0;
        #1;
        check("flush_idle_next", 64'(bus.stall), 64'd0);
        repeat (40) @(negedge clk);
        #1;
        check("flush_hi_lo_kept", {bus.hi, bus.lo}, {32'd0, 32'd15});

        // Asynchronous reset mid-BUSY, asserted off the clock edge.
        issue_mdu(6'b011000, 32'h0000_1234, 32'h0000_5678);
        repeat (5) @(negedge clk);
        #3;
        arst         = 1'b1;
        bus.valid_in = 1'b0;
        #1;
        check("arst_stall", 64'(bus.stall), 64'd0);
        check("arst_done", 64'(bus.mdu_done), 64'd0);
        check("arst_hi_lo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        arst = 1'b0;
        run_mdu(6'b011000, 32'd2, 32'd3, 32'd0, 32'd6, "mult_after_rst");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mdu_control.md
Name: alu_mdu_control

Overview:
Successor to the single-cycle ALU control decoder. Decodes alu_op and function_field into the 4-bit ALU control code, as before. Adds an iterative multiply/divide unit (MULT, MULTU, DIV, DIVU) with HI/LO registers, a pipeline stall handshake and a flush abort. Sits in the EX stage beside the ALU; the hazard unit consumes stall.

Parameters:
DATA_W, 32, operand width; HI and LO are each DATA_W bits; iteration count = DATA_W.
CNT_W, $clog2(DATA_W)+1, iteration counter width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
arst  in  1  asynchronous, active-high reset.
valid_in  in  1  EX holds a valid instruction.
flush  in  1  squash the EX instruction; aborts a running MDU op.
alu_op  in  2  0=ADD, 1=SUB, 2=R-type.
function_field  in  6  instruction funct field.
op_a  in  DATA_W  rs operand (multiplicand or dividend).
op_b  in  DATA_W  rt operand (multiplier or divisor).
alu_control  out  4  ALU operation code (combinational).
stall  out  1  freeze the pipeline (combinational from state and inputs).
mdu_done  out  1  one-cycle pulse; HI/LO were just updated.
hi  out  DATA_W  HI register.
lo  out  DATA_W  LO register.

Behaviour:
- Decode (combinational):
  - alu_op=0 -> 2 (ADD); alu_op=1 -> 5 (SUB); alu_op=3 -> 0.
  - alu_op=2 by funct: 100000->2, 100010->5, 100100->0, 100101->1, 100111->12, 101010->7, 000000->3, 000010->4, 010000 (MFHI)->8, 010010 (MFLO)->9.
  - MDU functs 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU -> 0.
  - Any other funct -> 0.
- mdu_start = valid_in & ~flush & alu_op==2 & funct is an MDU funct & state==IDLE.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY on mdu_start. In the same edge: latch |op_a|, |op_b| (raw values for unsigned ops), the result sign, op type; cnt=0.
  - BUSY: one bit per cycle. Multiply is shift-add into a 2*DATA_W accumulator; divide is restoring, one quotient bit per cycle. cnt increments each cycle. At cnt==DATA_W-1 -> DONE.
  - The last BUSY edge writes hi/lo with sign correction applied.
  - DONE -> IDLE unconditionally. A start is never taken in DONE, so the stalled MDU instruction does not re-issue.
- stall = mdu_start | (state==BUSY & ~flush). It is 0 in DONE.
- Stall length is DATA_W+1 cycles. Total occupancy is DATA_W+2 cycles.
- mdu_done = (state==DONE).
- Results:
  - MULT/MULTU: {hi,lo} = full 2*DATA_W product, signed or unsigned.
  - DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIV of MIN by -1: lo=MIN, hi=0.
  - Divide by zero (signed or unsigned): lo = all ones, hi = op_a unchanged. It still takes the full latency.
- flush in BUSY: go to IDLE at the next edge. hi/lo are unchanged and mdu_done stays 0.
- flush in IDLE or DONE has no MDU effect.
- valid_in low during BUSY is ignored; the op is committed.
- Reset (any time, including mid-op): state=IDLE, cnt=0, hi=0, lo=0, internal accumulators=0.
  - Outputs after reset: stall=0, mdu_done=0.
  - alu_control follows its inputs combinationally.
- An MFHI/MFLO in the cycle after DONE reads the new value; hi/lo are already registered.

Decomposition:
- Package alu_ctrl_pkg holds:
  - alu_op codes;
  - ALU control codes (0,1,2,3,4,5,7,8,9,12);
  - funct constants including the MDU/MFHI/MFLO functs;
  - FSM state encoding (IDLE=0, BUSY=1, DONE=2).
- One sub-module, mdu_iter: the iteration datapath (accumulator, shift-add step, restoring-subtract step, counter), controlled by load/step signals from the FSM in the top. Decode and the FSM stay in the top.

Test Plan:
- Decode sweep: alu_op=0 -> 2; alu_op=1 -> 5; alu_op=2 with funct 100111 -> 12; funct 000010 -> 4; funct 010010 -> 9; funct 111111 -> 0. stall stays 0 throughout.
- MULT 7 * 0xFFFFFFFD (-3): stall high for exactly 33 cycles starting at issue. mdu_done pulses 1 cycle later. hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001. Hold valid_in=1 through DONE and confirm no second start.
- DIV 0xFFFFFFF9 (-7) / 2: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 0: lo=0xFFFFFFFF, hi=0x00000064, after 33 stall cycles.
- Preload hi/lo via MULT 3*5 (hi=0, lo=15). Start DIVU 9/4 and assert flush in the 10th BUSY cycle: stall=0 the same cycle, IDLE next, mdu_done never pulses, hi=0, lo=15.
- Assert arst mid-BUSY, asynchronously off-edge: stall, mdu_done, hi and lo go to 0 immediately. After release, a new MULT 2*3 gives lo=6, hi=0 with normal latency.
